// File: rtl/hv_pwm_intb_encode.sv
// HV-side scheduler for the shared pwm_intb_n isolation line: forwards the PWM
// gate wave and, on an interrupt level change, inserts a short-pulse burst.
module hv_pwm_intb_encode #(
  parameter int PULSE_LO_CYC    = 6,
  parameter int PULSE_HI_CYC    = 2,
  parameter int GUARD_CYC       = 12,
  parameter int ASSERT_PULSES   = 1,
  parameter int DEASSERT_PULSES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hv_intb_n,
  input  logic i_pwm_gwave,
  output logic o_hv_pwm_intb_n,
  output logic o_busy,
  output logic o_intb_sent,
  output logic o_collision
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  localparam int CW   = $clog2(GUARD_CYC + 1);
  localparam int PMAX = (ASSERT_PULSES > DEASSERT_PULSES) ? ASSERT_PULSES : DEASSERT_PULSES;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [CW-1:0] GUARD_MAX  = CW'(GUARD_CYC);
  localparam logic [CW-1:0] LO_LAST    = CW'(PULSE_LO_CYC - 1);
  localparam logic [CW-1:0] HI_LAST    = CW'(PULSE_HI_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [PW-1:0] N_ASSERT   = PW'(ASSERT_PULSES);
  localparam logic [PW-1:0] N_DEASSERT = PW'(DEASSERT_PULSES);

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [PW-1:0] n_q, n_d;
  logic          tgt_q, tgt_d;
  logic          rpt_intb_n_q, rpt_intb_n_d;
  logic          out_q, out_d;
  logic          sent_q, sent_d;
  logic          launch;

  // State register and all datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cyc_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      pulse_cnt_q  <= '0;
      n_q          <= '0;
      tgt_q        <= 1'b1;
      rpt_intb_n_q <= 1'b1;
      out_q        <= 1'b1;
      sent_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      n_q          <= n_d;
      tgt_q        <= tgt_d;
      rpt_intb_n_q <= rpt_intb_n_d;
      out_q        <= out_d;
      sent_q       <= sent_d;
    end
  end

  // The guard time after a burst counts as idle when the gate wave stayed high,
  // which is what lets a pending opposite change launch straight after a burst.
  always_comb begin
    idle_cnt_d = '0;
    if (i_pwm_gwave) begin
      idle_cnt_d = (idle_cnt_q == GUARD_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end
  end

  assign launch = (i_hv_intb_n != rpt_intb_n_q) && (idle_cnt_q == GUARD_MAX) && i_pwm_gwave;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    cyc_cnt_d    = cyc_cnt_q + 1'b1;
    pulse_cnt_d  = pulse_cnt_q;
    n_d          = n_q;
    tgt_d        = tgt_q;
    rpt_intb_n_d = rpt_intb_n_q;
    sent_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_cnt_d   = '0;
        pulse_cnt_d = '0;
        if (launch) begin
          state_d = ST_LO;
          n_d     = rpt_intb_n_q ? N_ASSERT : N_DEASSERT;
          tgt_d   = i_hv_intb_n;
        end
      end
      ST_LO: begin
        if (cyc_cnt_q == LO_LAST) begin
          state_d     = ST_HI;
          cyc_cnt_d   = '0;
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      ST_HI: begin
        if (cyc_cnt_q == HI_LAST) begin
          cyc_cnt_d = '0;
          state_d   = (pulse_cnt_q < n_q) ? ST_LO : ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (cyc_cnt_q == GUARD_LAST) begin
          state_d      = ST_IDLE;
          cyc_cnt_d    = '0;
          rpt_intb_n_d = tgt_q;
          sent_d       = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cyc_cnt_d = '0;
      end
    endcase
  end

  // Output logic: the line register follows the state being entered, so a
  // launch in cycle T drives the line low from T+1.
  always_comb begin
    out_d = 1'b1;
    case (state_d)
      ST_IDLE: out_d = i_pwm_gwave;
      ST_LO:   out_d = 1'b0;
      default: out_d = 1'b1;
    endcase
  end

  assign o_hv_pwm_intb_n = out_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_intb_sent     = sent_q;
  assign o_collision     = o_busy & ~i_pwm_gwave;

endmodule

// File: tb/tb_hv_pwm_intb_encode.sv
// Directed bench for hv_pwm_intb_encode: burst shapes, LV decode, gwave
// blocking, collisions, back-to-back bursts and reset mid-burst.
module tb_hv_pwm_intb_encode;

  localparam int LO_W  = 6;
  localparam int HI_W  = 2;
  localparam int GRD_W = 12;

  logic clk;
  logic rst_n;
  logic hv_intb_n;
  logic pwm_gwave;
  logic line_n;
  logic busy;
  logic intb_sent;
  logic collision;

  int n_checks;
  int n_err;

  // Expected {line, busy} per cycle of a burst.
  logic [1:0] exp_q[$];

  hv_pwm_intb_encode dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_hv_intb_n     (hv_intb_n),
    .i_pwm_gwave     (pwm_gwave),
    .o_hv_pwm_intb_n (line_n),
    .o_busy          (busy),
    .o_intb_sent     (intb_sent),
    .o_collision     (collision)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with no burst expected; line must follow a high gwave.
  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_line"}, line_n, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_sent"}, intb_sent, 1'b0);
    end
  endtask

  // Called right after the inputs of launch cycle T are applied. Checks the
  // line T+1.. to the end of guard, o_intb_sent after it, decodes the line
  // like the LV side, and counts collision cycles.
  task automatic run_burst(input int n, input int exp_level, input int coll_start,
                           input int coll_len, input int flip_at, input string tag);
    logic [1:0] e;
    int i;
    int low_run;
    int pulses;
    int coll;
    int decoded;
    exp_q.delete();
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < LO_W; k++) exp_q.push_back(2'b01);
      for (int k = 0; k < HI_W; k++) exp_q.push_back(2'b11);
    end
    for (int k = 0; k < GRD_W; k++) exp_q.push_back(2'b11);
    i = 0;
    low_run = 0;
    pulses = 0;
    coll = 0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check({tag, "_line"}, line_n, e[1]);
      check({tag, "_busy"}, busy, e[0]);
      check({tag, "_sent_early"}, intb_sent, 1'b0);
      if (line_n == 1'b0) low_run++;
      else begin
        if (low_run >= 4 && low_run <= 8) pulses++;
        low_run = 0;
      end
      i++;
      pwm_gwave = (i >= coll_start && i < coll_start + coll_len) ? 1'b0 : 1'b1;
      if (i == flip_at) hv_intb_n = ~hv_intb_n;
      #1;
      if (collision) coll++;
    end
    tick();
    check({tag, "_sent"}, intb_sent, 1'b1);
    check({tag, "_busy_end"}, busy, 1'b0);
    decoded = (pulses == 1) ? 0 : (pulses == 4) ? 1 : 2;
    check({tag, "_lv_decode"}, decoded, exp_level);
    check({tag, "_collisions"}, coll, coll_len);
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    hv_intb_n = 1'b1;
    pwm_gwave = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_line", line_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_sent", intb_sent, 1'b0);
    check("rst_coll", collision, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset idle: 50 cycles, nothing happens.
    idle_cycles(50, "reset_idle");

    // Assert burst: 6 low, 2 high, 12 guard; sent at T+21.
    hv_intb_n = 1'b0;
    run_burst(1, 0, -1, 0, -1, "assert");
    idle_cycles(30, "after_assert");

    // Deassert burst: 4 x (6 low, 2 high) + 12 guard; sent at T+45.
    hv_intb_n = 1'b1;
    run_burst(4, 1, -1, 0, -1, "deassert");
    idle_cycles(20, "after_deassert");

    // Gwave low blocks launch; line follows gwave with a 1-cycle lag.
    hv_intb_n = 1'b0;
    pwm_gwave = 1'b0;
    tick();
    check("gw_line0", line_n, 1'b0);
    check("gw_busy0", busy, 1'b0);
    check("gw_coll0", collision, 1'b0);
    pwm_gwave = 1'b1;
    tick();
    check("gw_line1", line_n, 1'b1);
    check("gw_busy1", busy, 1'b0);
    pwm_gwave = 1'b0;
    tick();
    check("gw_line2", line_n, 1'b0);
    tick();
    check("gw_line3", line_n, 1'b0);
    check("gw_busy3", busy, 1'b0);
    pwm_gwave = 1'b1;
    idle_cycles(12, "gw_wait");
    run_burst(1, 0, -1, 0, -1, "gw_launch");

    // Collision: gwave low for 3 cycles during LO of a deassert burst.
    hv_intb_n = 1'b1;
    run_burst(4, 1, 2, 3, -1, "collide");
    idle_cycles(5, "after_collide");

    // intb falls, rises 5 cycles into the burst; deassert follows right after sent.
    hv_intb_n = 1'b0;
    run_burst(1, 0, -1, 0, 5, "toggle_a");
    run_burst(4, 1, -1, 0, -1, "toggle_d");
    idle_cycles(5, "after_toggle");

    // Reset mid-burst: assert first so the reported level is 0.
    hv_intb_n = 1'b0;
    run_burst(1, 0, -1, 0, -1, "pre_rst");
    hv_intb_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("mid_hi_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_line", line_n, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sent", intb_sent, 1'b0);
    tick();
    rst_n = 1'b1;
    // Reported level is back to 1, so intb_n=1 must not launch.
    idle_cycles(30, "post_rst");
    hv_intb_n = 1'b0;
    run_burst(1, 0, -1, 0, -1, "post_rst_assert");
    idle_cycles(5, "final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
